pipe_hazard_unit: RTL and testbench

Parametrised hazard controller for the pipelined core. It tracks in-flight register writes in a STAGES-deep scoreboard shift register and drives the core's pipeline control from decode-stage read/write addresses. Outputs are per-read-port forwarding selects, a load-use stall, a bubble into the decode/execute register, and a branch flush. It sits beside the control unit in register fetch and generalises the core's fixed two-port forwarding path to arbitrary depth, with an interlock-only mode.

---
 rtl/pipe_hazard_unit.sv | 85 ++++++++
 tb/tb_pipe_hazard_unit.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_unit.sv
// Pipeline hazard controller: scoreboard of in-flight writes, operand forwarding
// selects, load-use / interlock stall, decode bubble and branch flush.
module pipe_hazard_unit #(
    parameter int unsigned ADDR_W     = 4,
    parameter int unsigned STAGES     = 2,
    parameter int unsigned NOFWD_ADDR = 15,
    parameter int unsigned SEL_W      = $clog2(STAGES + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              hz_en,
    input  logic              id_valid,
    input  logic              id_rd_en0,
    input  logic              id_rd_en1,
    input  logic [ADDR_W-1:0] id_rd_addr0,
    input  logic [ADDR_W-1:0] id_rd_addr1,
    input  logic              id_wr_en,
    input  logic [ADDR_W-1:0] id_wr_addr,
    input  logic              id_is_load,
    input  logic              br_taken,
    output logic              stall,
    output logic              bubble,
    output logic              flush,
    output logic [SEL_W-1:0]  fwd_sel0,
    output logic [SEL_W-1:0]  fwd_sel1,
    output logic [15:0]       stall_count
);

    localparam logic [ADDR_W-1:0] NOFWD = ADDR_W'(NOFWD_ADDR);

    typedef struct packed {
        logic              v;
        logic [ADDR_W-1:0] addr;
        logic              ld;
    } sb_entry_t;

    sb_entry_t        sb [1:STAGES];
    logic [STAGES:1]  hit0;
    logic [STAGES:1]  hit1;
    logic [SEL_W-1:0] young0;
    logic [SEL_W-1:0] young1;
    logic             stall_i;

    // Per-entry address match; scanning oldest to youngest leaves the youngest hit.
    always_comb begin
        hit0   = '0;
        hit1   = '0;
        young0 = '0;
        young1 = '0;
        for (int k = int'(STAGES); k >= 1; k--) begin
            hit0[k] = id_valid & id_rd_en0 & sb[k].v & (sb[k].addr == id_rd_addr0)
                      & (id_rd_addr0 != NOFWD);
            hit1[k] = id_valid & id_rd_en1 & sb[k].v & (sb[k].addr == id_rd_addr1)
                      & (id_rd_addr1 != NOFWD);
            if (hit0[k]) young0 = SEL_W'(k);
            if (hit1[k]) young1 = SEL_W'(k);
        end
    end

    // Forwarding only blocks on a load still in execute; interlock blocks on any writer.
    always_comb begin
        stall_i = 1'b0;
        if (hz_en) stall_i = sb[1].ld & (hit0[1] | hit1[1]);
        else       stall_i = (|hit0) | (|hit1);
    end

    assign stall    = stall_i;
    assign bubble   = stall_i;
    assign flush    = br_taken & id_valid & ~stall_i;
    assign fwd_sel0 = (hz_en & ~stall_i) ? young0 : '0;
    assign fwd_sel1 = (hz_en & ~stall_i) ? young1 : '0;

    // Scoreboard shift; a stalled decode enters as a bubble.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 1; k <= int'(STAGES); k++) sb[k] <= '0;
            stall_count <= '0;
        end else begin
            for (int k = int'(STAGES); k >= 2; k--) sb[k] <= sb[k-1];
            sb[1] <= '{v: id_valid & id_wr_en & ~stall_i, addr: id_wr_addr, ld: id_is_load};
            if (stall_i && stall_count != 16'hFFFF) stall_count <= stall_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Bench for pipe_hazard_unit: STAGES=2 and STAGES=3 instances on shared stimulus,
// checked every cycle against an age-history model plus directed literal checks.
module tb_pipe_hazard_unit;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       hz_en = 1'b1;
    logic       id_valid = 1'b0, id_rd_en0 = 1'b0, id_rd_en1 = 1'b0;
    logic [3:0] id_rd_addr0 = '0, id_rd_addr1 = '0, id_wr_addr = '0;
    logic       id_wr_en = 1'b0, id_is_load = 1'b0, br_taken = 1'b0;

    logic       u2_stall, u2_bubble, u2_flush, u3_stall, u3_bubble, u3_flush;
    logic [1:0] u2_sel0, u2_sel1, u3_sel0, u3_sel1;
    logic [15:0] u2_cnt, u3_cnt;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    pipe_hazard_unit #(.ADDR_W(4), .STAGES(2), .NOFWD_ADDR(15)) u2 (
        .clk(clk), .reset(reset), .hz_en(hz_en), .id_valid(id_valid),
        .id_rd_en0(id_rd_en0), .id_rd_en1(id_rd_en1), .id_rd_addr0(id_rd_addr0),
        .id_rd_addr1(id_rd_addr1), .id_wr_en(id_wr_en), .id_wr_addr(id_wr_addr),
        .id_is_load(id_is_load), .br_taken(br_taken), .stall(u2_stall),
        .bubble(u2_bubble), .flush(u2_flush), .fwd_sel0(u2_sel0), .fwd_sel1(u2_sel1),
        .stall_count(u2_cnt));

    pipe_hazard_unit #(.ADDR_W(4), .STAGES(3), .NOFWD_ADDR(15)) u3 (
        .clk(clk), .reset(reset), .hz_en(hz_en), .id_valid(id_valid),
        .id_rd_en0(id_rd_en0), .id_rd_en1(id_rd_en1), .id_rd_addr0(id_rd_addr0),
        .id_rd_addr1(id_rd_addr1), .id_wr_en(id_wr_en), .id_wr_addr(id_wr_addr),
        .id_is_load(id_is_load), .br_taken(br_taken), .stall(u3_stall),
        .bubble(u3_bubble), .flush(u3_flush), .fwd_sel0(u3_sel0), .fwd_sel1(u3_sel1),
        .stall_count(u3_cnt));

    // Model: for each instance, what decode issued 1..depth cycles ago.
    bit          hv [2][1:3];
    logic [3:0]  ha [2][1:3];
    bit          hl [2][1:3];
    int unsigned hcnt [2];

    function automatic int depth(input int i);
        return (i == 0) ? 2 : 3;
    endfunction

    function automatic void model_eval(input int i, output bit st, output int s0,
                                       output int s1, output bit fl);
        int y0 = 0;
        int y1 = 0;
        for (int age = 1; age <= depth(i); age++) begin
            if (y0 == 0 && hv[i][age] && id_valid && id_rd_en0 &&
                ha[i][age] == id_rd_addr0 && id_rd_addr0 != 4'd15) y0 = age;
            if (y1 == 0 && hv[i][age] && id_valid && id_rd_en1 &&
                ha[i][age] == id_rd_addr1 && id_rd_addr1 != 4'd15) y1 = age;
        end
        if (hz_en) st = (y0 == 1 || y1 == 1) && hl[i][1];
        else       st = (y0 != 0) || (y1 != 0);
        s0 = (hz_en && !st) ? y0 : 0;
        s1 = (hz_en && !st) ? y1 : 0;
        fl = br_taken && id_valid && !st;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 2; i++) begin
                for (int a = 1; a <= 3; a++) hv[i][a] <= 1'b0;
                hcnt[i] <= 0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                bit st, fl;
                int s0, s1;
                model_eval(i, st, s0, s1, fl);
                for (int a = 3; a >= 2; a--) begin
                    hv[i][a] <= hv[i][a-1];
                    ha[i][a] <= ha[i][a-1];
                    hl[i][a] <= hl[i][a-1];
                end
                hv[i][1] <= id_valid && id_wr_en && !st;
                ha[i][1] <= id_wr_addr;
                hl[i][1] <= id_is_load;
                if (st && hcnt[i] < 32'hFFFF) hcnt[i] <= hcnt[i] + 1;
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    task automatic cmp_inst(input int i, input logic st, input logic bb, input logic fl,
                            input logic [1:0] s0, input logic [1:0] s1, input logic [15:0] cnt);
        bit est, efl;
        int es0, es1;
        model_eval(i, est, es0, es1, efl);
        chk($sformatf("stall%0d", depth(i)), int'(st), int'(est));
        chk($sformatf("bubble%0d", depth(i)), int'(bb), int'(est));
        chk($sformatf("flush%0d", depth(i)), int'(fl), int'(efl));
        chk($sformatf("sel0_%0d", depth(i)), int'(s0), es0);
        chk($sformatf("sel1_%0d", depth(i)), int'(s1), es1);
        chk($sformatf("count%0d", depth(i)), int'(cnt), int'(hcnt[i]));
    endtask

    always @(negedge clk) begin
        cmp_inst(0, u2_stall, u2_bubble, u2_flush, u2_sel0, u2_sel1, u2_cnt);
        cmp_inst(1, u3_stall, u3_bubble, u3_flush, u3_sel0, u3_sel1, u3_cnt);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic look();
        @(negedge clk);
        #1;
    endtask

    task automatic idle();
        id_valid = 0; id_rd_en0 = 0; id_rd_en1 = 0; id_wr_en = 0;
        id_is_load = 0; br_taken = 0;
        id_rd_addr0 = '0; id_rd_addr1 = '0; id_wr_addr = '0;
    endtask

    task automatic do_reset();
        reset = 0;
        idle();
        step();
        reset = 1;
    endtask

    task automatic wr(input logic [3:0] a, input logic ld);
        idle();
        id_valid = 1; id_wr_en = 1; id_wr_addr = a; id_is_load = ld;
    endtask

    task automatic rd0(input logic [3:0] a);
        idle();
        id_valid = 1; id_rd_en0 = 1; id_rd_addr0 = a;
    endtask

    task automatic rd1(input logic [3:0] a);
        idle();
        id_valid = 1; id_rd_en1 = 1; id_rd_addr1 = a;
    endtask

    initial begin
        // Reset state
        look();
        chk("rst_stall", int'(u2_stall), 0);
        chk("rst_sel0", int'(u2_sel0), 0);
        chk("rst_count", int'(u3_cnt), 0);

        // Forward from execute, then from entry 2
        do_reset();
        wr(4'd3, 0); step();
        rd0(4'd3); look();
        chk("fwd_ex_sel0", int'(u2_sel0), 1);
        chk("fwd_ex_stall", int'(u2_stall), 0);
        step(); look();
        chk("fwd_e2_sel0", int'(u2_sel0), 2);

        // Load-use: one stall cycle, then forward from entry 2
        do_reset();
        wr(4'd2, 1); step();
        rd1(4'd2); look();
        chk("lu_stall", int'(u2_stall), 1);
        chk("lu_bubble", int'(u2_bubble), 1);
        chk("lu_sel1_stalled", int'(u2_sel1), 0);
        step(); look();
        chk("lu_release", int'(u2_stall), 0);
        chk("lu_sel1", int'(u2_sel1), 2);
        chk("lu_count", int'(u2_cnt), 1);

        // Youngest writer wins; PC never forwarded
        do_reset();
        wr(4'd5, 0); step();
        wr(4'd5, 0); step();
        rd0(4'd5); look();
        chk("young_sel0", int'(u2_sel0), 1);
        do_reset();
        wr(4'd15, 1); step();
        rd0(4'd15); look();
        chk("pc_sel0", int'(u2_sel0), 0);
        chk("pc_stall", int'(u2_stall), 0);

        // Interlock mode, STAGES=3: three stall cycles
        do_reset();
        hz_en = 0;
        wr(4'd4, 0); step();
        rd0(4'd4);
        for (int c = 0; c < 3; c++) begin
            look();
            chk("il_stall", int'(u3_stall), 1);
            chk("il_sel0", int'(u3_sel0), 0);
            step();
        end
        look();
        chk("il_release", int'(u3_stall), 0);
        chk("il_count", int'(u3_cnt), 3);
        hz_en = 1;

        // Branch waiting under a load-use stall
        do_reset();
        wr(4'd1, 1); step();
        rd0(4'd1); br_taken = 1; look();
        chk("br_flush_stalled", int'(u2_flush), 0);
        chk("br_stall", int'(u2_stall), 1);
        step(); look();
        chk("br_flush", int'(u2_flush), 1);

        // Reset asserted mid-stall
        do_reset();
        wr(4'd2, 1); step();
        rd1(4'd2); look();
        chk("mid_stall_pre", int'(u2_stall), 1);
        reset = 0; #1;
        chk("mid_stall", int'(u2_stall), 0);
        chk("mid_count", int'(u2_cnt), 0);
        step();
        reset = 1; look();
        chk("mid_sel1", int'(u2_sel1), 0);
        chk("mid_stall_after", int'(u2_stall), 0);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            step();
            reset       = ($urandom_range(0, 199) != 0);
            if ($urandom_range(0, 49) == 0) hz_en = ~hz_en;
            id_valid    = ($urandom_range(0, 7) != 0);
            id_rd_en0   = $urandom_range(0, 1) == 1;
            id_rd_en1   = $urandom_range(0, 1) == 1;
            id_wr_en    = $urandom_range(0, 3) != 0;
            id_is_load  = $urandom_range(0, 2) == 0;
            br_taken    = $urandom_range(0, 5) == 0;
            id_rd_addr0 = ($urandom_range(0, 9) == 0) ? 4'd15 : 4'($urandom_range(0, 5));
            id_rd_addr1 = ($urandom_range(0, 9) == 0) ? 4'd15 : 4'($urandom_range(0, 5));
            id_wr_addr  = ($urandom_range(0, 9) == 0) ? 4'd15 : 4'($urandom_range(0, 5));
        end
        step();
        look();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
